// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with HI/LO registers and busy interlock
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDU_Start,
    input  logic [2:0]  E_MDU_Op,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic        E_MDU_RdSel,
    output logic        E_MDU_Busy,
    output logic [31:0] E_MDU_Out
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t         r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [31:0]    r_hi, r_lo, r_phi, r_plo;
    logic [31:0]    w_hi, w_lo, w_phi, w_plo;
    logic           r_dz, w_dz;

    logic               w_signed;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_neg_a, w_neg_b;
    logic [31:0]        w_mag_a, w_mag_b, w_den;
    logic [31:0]        w_uq, w_ur, w_quot, w_rem;

    // Even opcodes are the signed variants of MULT/DIV.
    assign w_signed = ~E_MDU_Op[0];

    assign w_prod_s = $signed({{32{E_MDU_A[31]}}, E_MDU_A}) * $signed({{32{E_MDU_B[31]}}, E_MDU_B});
    assign w_prod_u = {32'd0, E_MDU_A} * {32'd0, E_MDU_B};

    // Signed divide is done on magnitudes so that truncation toward zero and the
    // 0x80000000 / -1 overflow case fall out naturally (quotient wraps to 0x80000000).
    assign w_neg_a = w_signed & E_MDU_A[31];
    assign w_neg_b = w_signed & E_MDU_B[31];
    assign w_mag_a = w_neg_a ? 32'd0 - E_MDU_A : E_MDU_A;
    assign w_mag_b = w_neg_b ? 32'd0 - E_MDU_B : E_MDU_B;
    // A zero divisor is replaced by one only to keep the divider well defined; the
    // result is discarded at commit anyway.
    assign w_den  = (E_MDU_B == 32'd0) ? 32'd1 : w_mag_b;
    assign w_uq   = w_mag_a / w_den;
    assign w_ur   = w_mag_a % w_den;
    assign w_quot = (w_neg_a ^ w_neg_b) ? 32'd0 - w_uq : w_uq;
    assign w_rem  = w_neg_a ? 32'd0 - w_ur : w_ur;

    assign E_MDU_Busy = (r_state == S_BUSY);
    assign E_MDU_Out  = E_MDU_RdSel ? r_hi : r_lo;

    // Next-state: accept ops only when idle, count down while busy, commit on the last cycle.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_hi    = r_hi;
        w_lo    = r_lo;
        w_phi   = r_phi;
        w_plo   = r_plo;
        w_dz    = r_dz;
        if (r_state == S_IDLE) begin
            if (E_MDU_Start) begin
                case (E_MDU_Op)
                    OP_MULT, OP_MULTU: begin
                        w_state      = S_BUSY;
                        w_cnt        = CW'(MULT_CYCLES);
                        {w_phi, w_plo} = w_signed ? w_prod_s : w_prod_u;
                        w_dz         = 1'b0;
                    end
                    OP_DIV, OP_DIVU: begin
                        w_state = S_BUSY;
                        w_cnt   = CW'(DIV_CYCLES);
                        w_phi   = w_rem;
                        w_plo   = w_quot;
                        w_dz    = (E_MDU_B == 32'd0);
                    end
                    OP_MTHI: w_hi = E_MDU_A;
                    OP_MTLO: w_lo = E_MDU_A;
                    default: ;
                endcase
            end
        end else if (r_cnt == CW'(1)) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            w_hi    = r_dz ? r_hi : r_phi;
            w_lo    = r_dz ? r_lo : r_plo;
        end else begin
            w_cnt = r_cnt - CW'(1);
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_hi    <= w_hi;
            r_lo    <= w_lo;
            r_phi   <= w_phi;
            r_plo   <= w_plo;
            r_dz    <= w_dz;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized scoreboard bench for e_mdu against an arithmetic reference model
module tb_e_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_MDU_Start = 1'b0;
    logic [2:0]  E_MDU_Op = 3'd7;
    logic [31:0] E_MDU_A = '0;
    logic [31:0] E_MDU_B = '0;
    logic        E_MDU_RdSel = 1'b0;
    logic        E_MDU_Busy;
    logic [31:0] E_MDU_Out;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .E_MDU_Start(E_MDU_Start), .E_MDU_Op(E_MDU_Op),
        .E_MDU_A(E_MDU_A), .E_MDU_B(E_MDU_B), .E_MDU_RdSel(E_MDU_RdSel),
        .E_MDU_Busy(E_MDU_Busy), .E_MDU_Out(E_MDU_Out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   edge_n = 0;
    int   bcnt = 0;
    bit   chk = 1'b0;
    exp_t q_out[$];
    int   q_busy[$];

    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          pend = 1'b0, p_dz = 1'b0;
    int          busy_end = -1;

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares presented reads and measures every busy window.
    always @(negedge clk) begin
        if (chk) begin
            if (q_out.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_underflow: read presented with no expected value");
            end else begin
                exp_t e;
                e = q_out.pop_front();
                check(e.name, E_MDU_Out, e.val);
            end
        end
        if (!reset) bcnt = 0;
        else if (E_MDU_Busy) bcnt++;
        else if (bcnt > 0) begin
            if (q_busy.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL busy_unexpected: busy ran %0d cycles, expected none", bcnt);
            end else check("busy_len", 32'(bcnt), 32'(q_busy.pop_front()));
            bcnt = 0;
        end
    end

    task automatic model_sync(input int e);
        if (pend && e >= busy_end) begin
            pend = 1'b0;
            if (!p_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    endtask

    task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int     e;
        longint q, r;
        logic [63:0] p;
        @(posedge clk);
        #1 E_MDU_Start = 1'b1; E_MDU_Op = op; E_MDU_A = a; E_MDU_B = b;
        @(posedge clk);
        #1 E_MDU_Start = 1'b0; E_MDU_A = $urandom; E_MDU_B = $urandom;
        e = edge_n;
        if (e > busy_end) begin
            model_sync(e);
            if (op <= 3'd3) begin
                if (op == 3'd0) p = 64'(longint'($signed(a)) * longint'($signed(b)));
                else if (op == 3'd1) p = {32'd0, a} * {32'd0, b};
                else if (b == 32'd0) p = '0;
                else if (op == 3'd2) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    p = {r[31:0], q[31:0]};
                end else p = {a % b, a / b};
                {p_hi, p_lo} = p;
                p_dz = (op >= 3'd2) && (b == 32'd0);
                pend = 1'b1;
                busy_end = e + ((op < 3'd2) ? MC : DC);
                q_busy.push_back((op < 3'd2) ? MC : DC);
            end else if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!E_MDU_Busy) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: Busy=1 after 40 cycles, expected 0");
    endtask

    task automatic rd(input bit sel, input string name);
        @(posedge clk);
        #1 E_MDU_RdSel = sel;
        model_sync(edge_n);
        q_out.push_back('{name, sel ? m_hi : m_lo});
        chk = 1'b1;
        @(posedge clk);
        #1 chk = 1'b0;
    endtask

    task automatic rd_both(input string name);
        rd(1'b1, {name, "_hi"});
        rd(1'b0, {name, "_lo"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        #12;
        check("reset_busy", {31'd0, E_MDU_Busy}, 32'd0);
        check("reset_out", E_MDU_Out, 32'd0);
        @(negedge clk) reset = 1'b1;

        pulse(3'd0, 32'hFFFFFFFF, 32'h2);          wait_idle(); rd_both("mult");
        pulse(3'd1, 32'hFFFFFFFF, 32'h2);          wait_idle(); rd_both("multu");
        pulse(3'd2, 32'hFFFFFFF9, 32'h2);          wait_idle(); rd_both("div_neg");
        pulse(3'd3, 32'h7, 32'h2);                 wait_idle(); rd_both("divu");
        pulse(3'd2, 32'h80000000, 32'hFFFFFFFF);   wait_idle(); rd_both("div_ovf");

        pulse(3'd4, 32'h11, 32'h0);
        pulse(3'd5, 32'h22, 32'h0);
        pulse(3'd3, 32'h5, 32'h0);                 wait_idle(); rd_both("divu_zero");
        pulse(3'd2, 32'h5, 32'h0);                 wait_idle(); rd_both("div_zero");

        pulse(3'd0, 32'h1234, 32'h5678);
        pulse(3'd5, 32'hDEAD, 32'h0);
        wait_idle(); rd(1'b0, "mtlo_ignored");
        pulse(3'd0, 32'h3, 32'h4);
        wait_idle();
        pulse(3'd5, 32'hDEAD, 32'h0);
        rd(1'b0, "mtlo_after_busy");

        pulse(3'd4, 32'hA, 32'h0);
        pulse(3'd5, 32'hB, 32'h0);
        rd_both("rdsel");
        pulse(3'd0, 32'h2, 32'h3);
        rd_both("rdsel_busy");
        wait_idle(); rd_both("rdsel_commit");

        pulse(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        q_busy.delete();
        pend = 1'b0; m_hi = '0; m_lo = '0; busy_end = -1;
        #1 check("rst_busy", {31'd0, E_MDU_Busy}, 32'd0);
        check("rst_out_a", E_MDU_Out, 32'd0);
        E_MDU_RdSel = ~E_MDU_RdSel;
        #1 check("rst_out_b", E_MDU_Out, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (15) @(posedge clk);
        rd_both("rst_nocommit");

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            pulse(op, a, b);
            repeat ($urandom_range(0, 6)) @(posedge clk);
            if ($urandom_range(0, 1) == 1) rd(1'($urandom_range(0, 1)), "rand");
        end
        wait_idle();
        rd_both("rand_final");

        repeat (3) @(posedge clk);
        check("queues_drained", 32'(q_out.size() + q_busy.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
